// File: rtl/data_mem_responder_pkg.sv
// Shared memory-op encoding for the data-memory responder and the control unit:
// READ_WRITE op codes, FSM state type and a size/unsigned field decode.
package data_mem_responder_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LB  = 4'b1000;
   localparam logic [3:0] OP_LH  = 4'b1001;
   localparam logic [3:0] OP_LW  = 4'b1010;
   localparam logic [3:0] OP_LBU = 4'b1100;
   localparam logic [3:0] OP_LHU = 4'b1101;
   localparam logic [3:0] OP_SB  = 4'b0100;
   localparam logic [3:0] OP_SH  = 4'b0101;
   localparam logic [3:0] OP_SW  = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef struct packed {
      logic  is_load;
      logic  is_store;
      size_t size;
      logic  is_unsigned;
   } op_dec_t;

   // Unlisted codes decode as neither load nor store, i.e. NOP.
   function automatic op_dec_t decode_op(input logic [3:0] op);
      op_dec_t d;
      d.is_load     = 1'b0;
      d.is_store    = 1'b0;
      d.size        = SZ_WORD;
      d.is_unsigned = 1'b0;
      case (op)
         OP_LB:  begin d.is_load = 1'b1; d.size = SZ_BYTE; end
         OP_LH:  begin d.is_load = 1'b1; d.size = SZ_HALF; end
         OP_LW:  begin d.is_load = 1'b1; d.size = SZ_WORD; end
         OP_LBU: begin d.is_load = 1'b1; d.size = SZ_BYTE; d.is_unsigned = 1'b1; end
         OP_LHU: begin d.is_load = 1'b1; d.size = SZ_HALF; d.is_unsigned = 1'b1; end
         OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
         OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
         OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic is_aligned(input size_t sz, input logic [1:0] addr_lo);
      logic ok;
      case (sz)
         SZ_HALF: ok = ~addr_lo[0];
         SZ_WORD: ok = (addr_lo == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_responder_load_store_align.sv
// Byte-lane steering for the data memory: store byte enables and replicated
// write word, plus extraction and sign/zero extension of load data.
module load_store_align
   import data_mem_responder_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wword,
   output logic [31:0] o_ldata
);

   op_dec_t            w_dec;
   logic signed [7:0]  w_byte;
   logic signed [15:0] w_half;

   assign w_dec = decode_op(i_op);

   always_comb begin
      o_be    = 4'b0000;
      o_wword = i_wdata;
      o_ldata = i_rword;
      w_byte  = i_rword[{i_addr_lo, 3'b000} +: 8];
      w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
      case (w_dec.size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wword = {4{i_wdata[7:0]}};
            o_ldata = w_dec.is_unsigned ? {24'd0, w_byte} : 32'(w_byte);
         end
         SZ_HALF: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wword = {2{i_wdata[15:0]}};
            o_ldata = w_dec.is_unsigned ? {16'd0, w_half} : 32'(w_half);
         end
         default: begin
            o_be    = 4'b1111;
            o_wword = i_wdata;
            o_ldata = i_rword;
         end
      endcase
      // Lanes only matter when a store actually commits.
      if (!w_dec.is_store) o_be = 4'b0000;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: multi-cycle byte/half/word loads and stores on a
// word-organised array, stalling the pipeline through BUSYWAIT.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  READ_WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        MISALIGNED
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   // The request cycle in IDLE counts toward LATENCY, so BUSY lasts LATENCY-1 cycles.
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [3:0]    r_op;
   logic [1:0]    r_addr_lo;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic [31:0]   r_mem [DEPTH_WORDS];

   op_dec_t       w_dec, w_rdec;
   logic          w_req, w_aligned, w_start, w_final;
   logic [31:0]   w_rword, w_wword, w_ldata;
   logic [3:0]    w_be;
   logic          w_unused_addr;

   assign w_dec         = decode_op(READ_WRITE);
   assign w_rdec        = decode_op(r_op);
   assign w_req         = w_dec.is_load | w_dec.is_store;
   assign w_aligned     = is_aligned(w_dec.size, ADDRESS[1:0]);
   assign w_rword       = r_mem[r_idx];
   assign w_final       = RESET && (r_state == ST_BUSY) && (r_cnt == 4'd0);
   assign w_unused_addr = ^ADDRESS[31:AW+2];
   assign READ_DATA     = r_rdata;

   load_store_align u_align (
      .i_op      (r_op),
      .i_addr_lo (r_addr_lo),
      .i_rword   (w_rword),
      .i_wdata   (r_wdata),
      .o_be      (w_be),
      .o_wword   (w_wword),
      .o_ldata   (w_ldata)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      BUSYWAIT    = 1'b0;
      MISALIGNED  = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (w_aligned) begin
                  BUSYWAIT    = 1'b1;
                  w_start     = 1'b1;
                  w_state_nxt = ST_BUSY;
                  w_cnt_nxt   = CNT_INIT;
               end else begin
                  MISALIGNED  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            BUSYWAIT = 1'b1;
            if (r_cnt == 4'd0) w_state_nxt = ST_DONE;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      // Reset masks the combinational request path so inputs cannot leak through.
      if (!RESET) begin
         BUSYWAIT   = 1'b0;
         MISALIGNED = 1'b0;
         w_start    = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_start) begin
         r_op      <= READ_WRITE;
         r_addr_lo <= ADDRESS[1:0];
         r_idx     <= ADDRESS[AW+1:2];
         r_wdata   <= WRITE_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                         r_rdata <= 32'd0;
      else if (w_final && w_rdec.is_load) r_rdata <= w_ldata;
   end

   // Array is never reset; an aborted store simply never reaches w_final.
   always_ff @(posedge CLK) begin
      if (w_final && w_rdec.is_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus
// hand sequences for reset, misalignment and back-to-back accesses.
module tb_data_mem_responder;

   localparam logic [3:0] NOP = 4'b0000;
   localparam logic [3:0] LB  = 4'b1000;
   localparam logic [3:0] LH  = 4'b1001;
   localparam logic [3:0] LW  = 4'b1010;
   localparam logic [3:0] LBU = 4'b1100;
   localparam logic [3:0] LHU = 4'b1101;
   localparam logic [3:0] SB  = 4'b0100;
   localparam logic [3:0] SH  = 4'b0101;
   localparam logic [3:0] SW  = 4'b0110;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  rw;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;
   logic        mis;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs [19];

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
      .CLK        (clk),
      .RESET      (rst_n),
      .READ_WRITE (rw),
      .ADDRESS    (addr),
      .WRITE_DATA (wd),
      .READ_DATA  (rd),
      .BUSYWAIT   (busy),
      .MISALIGNED (mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one request and follows it to its DONE cycle (bounded wait).
   task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, output int nb, output logic [31:0] rdv,
                         output logic misv);
      nb   = 0;
      misv = 1'b0;
      @(negedge clk);
      rw   = op;
      addr = a;
      wd   = d;
      #1;
      while (busy === 1'b1 && nb < 40) begin
         misv = misv | mis;
         nb++;
         @(posedge clk);
         #1;
      end
      misv = misv | mis;
      rdv  = rd;
      @(posedge clk);
      #1;
      if (!hold) rw = NOP;
   endtask

   initial begin
      int          nb;
      logic [31:0] rdv;
      logic        misv;

      vecs[0]  = '{SW,  32'h10,  32'hDEADBEEF, 32'h00000000};
      vecs[1]  = '{LW,  32'h10,  32'h0,        32'hDEADBEEF};
      vecs[2]  = '{LB,  32'h13,  32'h0,        32'hFFFFFFDE};
      vecs[3]  = '{LBU, 32'h13,  32'h0,        32'h000000DE};
      vecs[4]  = '{LH,  32'h10,  32'h0,        32'hFFFFBEEF};
      vecs[5]  = '{LHU, 32'h12,  32'h0,        32'h0000DEAD};
      vecs[6]  = '{SB,  32'h11,  32'h00000055, 32'h0000DEAD};
      vecs[7]  = '{LW,  32'h10,  32'h0,        32'hDEAD55EF};
      vecs[8]  = '{LW,  32'h410, 32'h0,        32'hDEAD55EF};
      vecs[9]  = '{SW,  32'h20,  32'hCAFEF00D, 32'hDEAD55EF};
      vecs[10] = '{SW,  32'h30,  32'h80FF7F01, 32'hDEAD55EF};
      vecs[11] = '{LB,  32'h30,  32'h0,        32'h00000001};
      vecs[12] = '{LB,  32'h31,  32'h0,        32'h0000007F};
      vecs[13] = '{LB,  32'h32,  32'h0,        32'hFFFFFFFF};
      vecs[14] = '{LBU, 32'h33,  32'h0,        32'h00000080};
      vecs[15] = '{LH,  32'h32,  32'h0,        32'hFFFF80FF};
      vecs[16] = '{SH,  32'h32,  32'h1234ABCD, 32'hFFFF80FF};
      vecs[17] = '{LW,  32'h30,  32'h0,        32'hABCD7F01};
      vecs[18] = '{LHU, 32'h30,  32'h0,        32'h00007F01};

      // Reset held low across a clock edge with a store presented.
      rst_n = 1'b0;
      rw    = SW;
      addr  = 32'h10;
      wd    = 32'hFFFFFFFF;
      #2;
      check("reset_busywait", {31'd0, busy}, 32'd0);
      check("reset_read_data", rd, 32'd0);
      check("reset_misaligned", {31'd0, mis}, 32'd0);
      #4;
      check("reset_busywait_after_edge", {31'd0, busy}, 32'd0);
      #1;
      rst_n = 1'b1;
      rw    = NOP;
      #1;
      check("idle_nop_busywait", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check("idle_after_release", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 19; i++) begin
         access(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, nb, rdv, misv);
         check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'd4);
         check($sformatf("vec%0d_read_data", i), rdv, vecs[i].exp_rd);
         check($sformatf("vec%0d_misaligned", i), {31'd0, misv}, 32'd0);
      end

      // Same load held through DONE: a second full access follows.
      access(LW, 32'h10, 32'h0, 1'b1, nb, rdv, misv);
      check("b2b_first_busy_cycles", 32'(nb), 32'd4);
      check("b2b_first_read_data", rdv, 32'hDEAD55EF);
      check("b2b_rerequest_busywait", {31'd0, busy}, 32'd1);
      access(LW, 32'h10, 32'h0, 1'b0, nb, rdv, misv);
      check("b2b_second_busy_cycles", 32'(nb), 32'd4);
      check("b2b_second_read_data", rdv, 32'hDEAD55EF);

      // Misaligned word load and half store stay in IDLE.
      @(negedge clk);
      rw   = LW;
      addr = 32'h12;
      #1;
      check("mis_lw_flag", {31'd0, mis}, 32'd1);
      check("mis_lw_busywait", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check("mis_lw_flag_next", {31'd0, mis}, 32'd1);
      check("mis_lw_busywait_next", {31'd0, busy}, 32'd0);
      check("mis_lw_read_data", rd, 32'hDEAD55EF);
      @(negedge clk);
      rw   = SH;
      addr = 32'h11;
      wd   = 32'h0000FFFF;
      #1;
      check("mis_sh_flag", {31'd0, mis}, 32'd1);
      check("mis_sh_busywait", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rw = 4'b0111;
      #1;
      check("undef_op_busywait", {31'd0, busy}, 32'd0);
      check("undef_op_misaligned", {31'd0, mis}, 32'd0);
      rw = NOP;
      access(LW, 32'h10, 32'h0, 1'b0, nb, rdv, misv);
      check("mis_sh_no_write", rdv, 32'hDEAD55EF);

      // Reset during the second BUSY cycle aborts the store.
      @(negedge clk);
      rw   = SW;
      addr = 32'h20;
      wd   = 32'h12345678;
      @(posedge clk);
      #1;
      check("abort_busy_cycle1", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busywait_drop", {31'd0, busy}, 32'd0);
      check("abort_misaligned", {31'd0, mis}, 32'd0);
      check("abort_read_data_cleared", rd, 32'd0);
      @(posedge clk);
      #1;
      check("abort_busywait_held_low", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rw    = NOP;
      access(LW, 32'h20, 32'h0, 1'b0, nb, rdv, misv);
      check("abort_busy_cycles", 32'(nb), 32'd4);
      check("abort_store_not_committed", rdv, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
